// File: rtl/key_meas_ctrl.sv
// Sequencing controller between the key block and the frequency/period core:
// key-driven configuration, start/done/abort handshake, display hold, watchdog, LEDs.
module key_meas_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TICK_HZ    = 1_000,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200,
  parameter int HOLD_MS    = 500,
  parameter int TIMEOUT_MS = 12000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key_pos,
  input  logic [3:0] key_lvl,
  input  logic       meas_done,
  output logic       meas_start,
  output logic       meas_abort,
  output logic       meas_busy,
  output logic [1:0] mode,
  output logic [1:0] gate_sel,
  output logic       single,
  output logic       run,
  output logic       timeout_err,
  output logic [2:0] state,
  output logic [7:0] led
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] C_TICK_LAST = TW'(DIV - 1);
  localparam logic [15:0]   C_LONG = 16'(LONG_MS);
  localparam logic [15:0]   C_REP  = 16'(REPEAT_MS);
  localparam logic [15:0]   C_HOLD = 16'(HOLD_MS);
  localparam logic [15:0]   C_TO   = 16'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARM = 3'd1, S_MEAS = 3'd2, S_HOLD = 3'd3, S_ERR = 3'd4
  } state_t;

  state_t      r_state, w_nxt_state;
  logic [TW-1:0] r_tick_cnt;
  logic [15:0] r_held, r_rep, r_hold, r_wd;
  logic [1:0]  r_mode, r_gate, w_nxt_mode, w_nxt_gate;
  logic        r_single, r_run, r_terr, r_abort;
  logic        w_nxt_single, w_nxt_run, w_nxt_terr, w_nxt_abort;
  logic [7:0]  r_led;
  logic        w_tick, w_rep, w_cfg_ok, w_cfg, w_hold_exp, w_wd_exp;
  logic [3:0]  w_k;
  logic        w_unused;

  assign w_unused = ^{key_lvl[3:2], key_lvl[0]};
  assign w_tick   = (r_tick_cnt == C_TICK_LAST);

  // Lowest set bit wins; the rest of a multi-key cycle is dropped.
  assign w_k      = key_pos & (~key_pos + 4'd1);
  assign w_cfg_ok = (r_state == S_IDLE) || (r_state == S_HOLD);

  // First repeat step on the LONG_MS-th held tick, then every REPEAT_MS ticks.
  assign w_rep = key_lvl[1] && w_tick &&
                 ((r_held == C_LONG - 16'd1) || (r_held == C_LONG && r_rep == C_REP - 16'd1));
  assign w_cfg      = w_k[0] | w_k[1] | w_k[3] | w_rep;
  assign w_hold_exp = (r_state == S_HOLD) && w_tick && (r_hold == C_HOLD - 16'd1);
  assign w_wd_exp   = (r_state == S_MEAS) && w_tick && (r_wd == C_TO - 16'd1);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_tick_cnt <= '0;
      r_held     <= '0;
      r_rep      <= '0;
      r_hold     <= '0;
      r_wd       <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (!key_lvl[1]) begin
        r_held <= '0;
        r_rep  <= '0;
      end else if (w_tick) begin
        if (r_held != C_LONG)          r_held <= r_held + 16'd1;
        else if (r_rep == C_REP - 16'd1) r_rep <= '0;
        else                           r_rep  <= r_rep + 16'd1;
      end
      if (r_state != S_HOLD) r_hold <= '0;
      else if (w_tick)       r_hold <= r_hold + 16'd1;
      if (r_state != S_MEAS) r_wd <= '0;
      else if (w_tick)       r_wd <= r_wd + 16'd1;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_mode   = r_mode;
    w_nxt_gate   = r_gate;
    w_nxt_single = r_single;
    w_nxt_run    = r_run;
    w_nxt_terr   = r_terr;
    w_nxt_abort  = 1'b0;
    if (w_cfg_ok) begin
      if (w_k[0])         w_nxt_mode   = r_mode + 2'd1;
      if (w_k[1] | w_rep) w_nxt_gate   = r_gate + 2'd1;
      if (w_k[3])         w_nxt_single = ~r_single;
    end
    case (r_state)
      S_IDLE: begin
        if (w_k[2]) w_nxt_run = ~r_run;
        if (r_run)  w_nxt_state = S_ARM;
      end
      S_ARM: w_nxt_state = S_MEAS;
      S_MEAS: begin
        // done beats both a stop key and watchdog expiry in the same cycle
        if (meas_done) begin
          if (r_single || w_k[2]) begin
            w_nxt_run   = 1'b0;
            w_nxt_state = S_IDLE;
          end else begin
            w_nxt_state = S_HOLD;
          end
        end else if (w_k[2]) begin
          w_nxt_run   = 1'b0;
          w_nxt_abort = 1'b1;
          w_nxt_state = S_IDLE;
        end else if (w_wd_exp) begin
          w_nxt_run   = 1'b0;
          w_nxt_abort = 1'b1;
          w_nxt_terr  = 1'b1;
          w_nxt_state = S_ERR;
        end
      end
      S_HOLD: begin
        if (w_k[2]) begin
          w_nxt_run   = 1'b0;
          w_nxt_state = S_IDLE;
        end else if (w_cfg || w_hold_exp) begin
          w_nxt_state = S_ARM;
        end
      end
      S_ERR: begin
        if (|key_pos) begin
          w_nxt_terr  = 1'b0;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state  <= S_IDLE;
      r_mode   <= 2'd0;
      r_gate   <= 2'd2;
      r_single <= 1'b0;
      r_run    <= 1'b0;
      r_terr   <= 1'b0;
      r_abort  <= 1'b0;
      r_led    <= 8'hFF;
    end else begin
      r_state  <= w_nxt_state;
      r_mode   <= w_nxt_mode;
      r_gate   <= w_nxt_gate;
      r_single <= w_nxt_single;
      r_run    <= w_nxt_run;
      r_terr   <= w_nxt_terr;
      r_abort  <= w_nxt_abort;
      r_led    <= ~{r_terr, (r_state == S_MEAS), r_single, r_run, r_gate, r_mode};
    end
  end

  assign meas_start  = (r_state == S_ARM);
  assign meas_busy   = (r_state == S_MEAS);
  assign meas_abort  = r_abort;
  assign mode        = r_mode;
  assign gate_sel    = r_gate;
  assign single      = r_single;
  assign run         = r_run;
  assign timeout_err = r_terr;
  assign state       = r_state;
  assign led         = r_led;

endmodule
